// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/subtract arbiter slice.
//   DEF_WIDTH : default operand/result width
//   state_t   : FSM encoding (IDLE / EXEC / RESP)
//   req_id_t  : requester index carried with each operation (0 or 1)
package addsub_arbiter_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bus between two requesters, the arbiter and a result consumer.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req{0,1}_a/_b/_sub  : operands and operation select per requester
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/result/overflow : tagged response payload
// Handshake semantics: a transfer happens on a rising clock edge where valid and
// ready are both 1. A source holds valid and payload stable until that transfer.
// req_ready may depend combinationally on req_valid; rsp_valid never depends on
// rsp_ready. Response payload is stable for as long as rsp_valid is 1.
interface addsub_arbiter_if
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic             rsp_valid;
    logic             rsp_ready;
    req_id_t          rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_overflow;

    // Requester/consumer side
    modport master (
        output req_valid, req0_a, req0_b, req0_sub, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
    );

    // Arbiter side
    modport slave (
        input  req_valid, req0_a, req0_b, req0_sub, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
    );

endinterface

// File: rtl/addsub_arbiter_core.sv
// Combinational signed add/subtract with two's-complement overflow detection.
//   a_i, b_i     : operands (signed two's complement)
//   sub_i        : 1 = a-b, 0 = a+b
//   result_o     : result modulo 2^WIDTH
//   overflow_o   : signed overflow of result_o
module addsub_core
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] b_eff;

    // Subtraction reuses the single adder: a + ~b + 1, the +1 entering as carry-in.
    assign b_eff    = sub_i ? ~b_i : b_i;
    assign result_o = a_i + b_eff + {{(WIDTH-1){1'b0}}, sub_i};

    // Sign rules on the original operands; covers b = most-negative correctly.
    always_comb begin
        overflow_o = 1'b0;
        if (sub_i) begin
            overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
        end else begin
            overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract unit between two requesters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request/response interface (slave modport)
//   ovf_clr     : synchronous clear of ovf_sticky
//   ovf_sticky  : set by any delivered overflowing result, held until cleared
//   state_o     : current FSM state (debug observation)
// One operation is in flight at a time: IDLE accepts, EXEC computes, RESP holds
// the result until the consumer takes it.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    addsub_arbiter_if.slave     bus,
    input  logic                ovf_clr,
    output logic                ovf_sticky,
    output state_t              state_o
);

    state_t           state_q, state_d;
    req_id_t          prio_q;
    req_id_t          grant;
    logic             accept;
    logic [1:0]       req_ready;

    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q;
    req_id_t          id_q;

    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_ovf_q;
    req_id_t          rsp_id_q;
    logic             sticky_q;

    logic [WIDTH-1:0] core_result;
    logic             core_ovf;
    logic             rsp_hs;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a_i        (a_q),
        .b_i        (b_q),
        .sub_i      (sub_q),
        .result_o   (core_result),
        .overflow_o (core_ovf)
    );

    // Grant and next state. Ready is offered only to a requester that is valid,
    // so nothing is advertised while both inputs are idle.
    always_comb begin
        state_d   = state_q;
        grant     = prio_q;
        req_ready = 2'b00;
        accept    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (bus.req_valid)
                    2'b01:   grant = 1'b0;
                    2'b10:   grant = 1'b1;
                    default: grant = prio_q;
                endcase
                req_ready = bus.req_valid & (grant ? 2'b10 : 2'b01);
                if (bus.req_valid != 2'b00) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prio_q       <= RR_INIT;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= grant ? bus.req1_a   : bus.req0_a;
                b_q    <= grant ? bus.req1_b   : bus.req0_b;
                sub_q  <= grant ? bus.req1_sub : bus.req0_sub;
                id_q   <= grant;
                prio_q <= ~grant;
            end
            // Response registers load only at the end of EXEC, so they stay put in RESP.
            if (state_q == ST_EXEC) begin
                rsp_result_q <= core_result;
                rsp_ovf_q    <= core_ovf;
                rsp_id_q     <= id_q;
            end
            // A delivered overflow wins over a simultaneous clear.
            if (rsp_hs && rsp_ovf_q) begin
                sticky_q <= 1'b1;
            end else if (ovf_clr) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign ovf_sticky       = sticky_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;
    import addsub_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   ovf_clr = 1'b0;
    logic   ovf_sticky;
    state_t dbg_state;

    always #5 clk = ~clk;

    addsub_arbiter_if #(.WIDTH(16)) bus ();

    addsub_arbiter #(.WIDTH(16), .RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
        .state_o    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int   n_checks = 0;
    int   n_errors = 0;
    logic model_sticky = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] exp_r;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {30'd0, bus.req_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_id"}, {31'd0, bus.rsp_id}, 32'd0);
        check({tag, "_rsp_result"}, {16'd0, bus.rsp_result}, 32'd0);
        check({tag, "_rsp_ovf"}, {31'd0, bus.rsp_overflow}, 32'd0);
        check({tag, "_sticky"}, {31'd0, ovf_sticky}, 32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    // One complete single-requester operation: request, latency check, payload
    // check, handshake (optionally with ovf_clr asserted alongside), sticky check.
    task automatic do_op(input string name, input logic id, input logic [15:0] a,
                         input logic [15:0] b, input logic sub,
                         input logic [15:0] er, input logic eo, input logic clr);
        int lat;
        @(negedge clk);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req_valid = 2'b10;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req_valid = 2'b01;
        end
        #1;
        check({name, "_req_ready"}, {30'd0, bus.req_ready}, id ? 32'd2 : 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 32'd2);
        check({name, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({name, "_rsp_id"}, {31'd0, bus.rsp_id}, {31'd0, id});
        check({name, "_rsp_result"}, {16'd0, bus.rsp_result}, {16'd0, er});
        check({name, "_rsp_ovf"}, {31'd0, bus.rsp_overflow}, {31'd0, eo});
        bus.rsp_ready = 1'b1;
        ovf_clr = clr;
        if (eo) model_sticky = 1'b1;
        else if (clr) model_sticky = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        ovf_clr = 1'b0;
        #1;
        check({name, "_done_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({name, "_sticky"}, {31'd0, ovf_sticky}, {31'd0, model_sticky});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_sticky = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_grant;
        int n_rsp;
        int cyc;

        vecs[0] = '{1'b0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0};
        vecs[1] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1};
        vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1};
        vecs[8] = '{1'b0, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0};

        idle_inputs();
        #12;
        check_reset_outputs("por");
        apply_reset();

        // Both requesters valid continuously from reset: grants alternate 0,1,0,1.
        @(negedge clk);
        bus.req0_a = 16'd1;  bus.req0_b = 16'd1; bus.req0_sub = 1'b0;
        bus.req1_a = 16'd10; bus.req1_b = 16'd3; bus.req1_sub = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        n_grant = 0;
        n_rsp = 0;
        cyc = 0;
        while (n_rsp < 4 && cyc < 60) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                if (n_grant < 4)
                    check("rr_grant", {30'd0, bus.req_ready}, (n_grant % 2) ? 32'd2 : 32'd1);
                n_grant++;
            end
            if (bus.rsp_valid) begin
                check("rr_rsp_id", {31'd0, bus.rsp_id}, (n_rsp % 2) ? 32'd1 : 32'd0);
                check("rr_rsp_result", {16'd0, bus.rsp_result}, (n_rsp % 2) ? 32'd7 : 32'd2);
                n_rsp++;
            end
            if (n_rsp < 4) @(negedge clk);
            cyc++;
        end
        bus.req_valid = 2'b00;
        check("rr_rsp_count", n_rsp, 32'd4);
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        apply_reset();

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub,
                  vecs[i].exp_r, vecs[i].exp_ovf, 1'b0);
        end

        // Reset while EXEC: everything returns to reset values, no response later.
        @(negedge clk);
        bus.req1_a = 16'h7FFF; bus.req1_b = 16'h0001; bus.req1_sub = 1'b0;
        bus.req_valid = 2'b10;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        check("rstexec_state", {30'd0, dbg_state}, {30'd0, ST_EXEC});
        rst_n = 1'b0;
        model_sticky = 1'b0;
        #1;
        check_reset_outputs("rstexec");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstexec_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        bus.rsp_ready = 1'b0;

        // Backpressure: result held for 5 cycles, no new grant while busy.
        @(negedge clk);
        bus.req0_a = 16'h0100; bus.req0_b = 16'h0023; bus.req0_sub = 1'b0;
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        check("bp_exec_ready", {30'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_result", {16'd0, bus.rsp_result}, 32'h0123);
            check("bp_id", {31'd0, bus.rsp_id}, 32'd0);
            check("bp_ovf", {31'd0, bus.rsp_overflow}, 32'd0);
            check("bp_ready", {30'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_released", {31'd0, bus.rsp_valid}, 32'd0);

        // Sticky flag: set, plain clear, set-beats-clear, clear on quiet handshake.
        do_op("stk_set", 1'b1, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0);
        @(negedge clk);
        ovf_clr = 1'b1;
        model_sticky = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        check("stk_clr", {31'd0, ovf_sticky}, {31'd0, model_sticky});
        do_op("stk_set_wins", 1'b0, 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b1);
        do_op("stk_clr_hs", 1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
